// File: rtl/cache_fill_controller.sv
// Miss-fill FSM for the 2-way caches: picks the LRU victim, streams an
// 8-word block from pipelined memory, then writes tag/valid and LRU.
module cache_fill_controller #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic                               block0_isLRU,
  input  logic                               block1_isLRU,
  input  logic                               mem_data_valid,
  output logic                               fsm_busy,
  output logic                               mem_en,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_offset,
  output logic                               fill_way,
  output logic                               write_tag_array,
  output logic                               lru_write_en,
  output logic                               lru_block
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = IDX_W + 1;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK =
    {{(ADDR_W-OFF_W){1'b0}}, {OFF_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              fill_way_q, fill_way_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;

  logic issue_ok;
  logic recv_ok;

  // counters saturate at FULL, so late valids fall through
  assign issue_ok = (state_q == S_FILL) && (issue_cnt_q < FULL);
  assign recv_ok  = (state_q == S_FILL) && (recv_cnt_q < FULL)
                  && mem_data_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      fill_way_q  <= 1'b0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      fill_way_q  <= fill_way_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    fill_way_d  = fill_way_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (miss_detected) begin
          base_d      = miss_address & ~OFF_MASK;
          // way 1 only when it alone is LRU
          fill_way_d  = block1_isLRU & ~block0_isLRU;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = S_FILL;
        end
      end
      S_FILL: begin
        if (issue_ok) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (recv_ok) begin
          recv_cnt_d = recv_cnt_q + 1'b1;
          if (recv_cnt_q == LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    fsm_busy         = (state_q != S_IDLE);
    fill_way         = fill_way_q;
    mem_en           = 1'b0;
    mem_addr         = '0;
    write_data_array = 1'b0;
    word_offset      = '0;
    write_tag_array  = 1'b0;
    lru_write_en     = 1'b0;
    lru_block        = 1'b0;
    unique case (state_q)
      S_FILL: begin
        mem_en = issue_ok;
        if (issue_ok) begin
          mem_addr = base_q
            + {{(ADDR_W-CNT_W-1){1'b0}}, issue_cnt_q, 1'b0};
        end
        write_data_array = recv_ok;
        if (recv_ok) begin
          word_offset = recv_cnt_q[IDX_W-1:0];
        end
      end
      S_DONE: begin
        write_tag_array = 1'b1;
        lru_write_en    = 1'b1;
        lru_block       = ~fill_way_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_controller.sv
// Randomized bench for cache_fill_controller: transaction-level model
// checked every cycle, plus directed literal checks.
module tb_cache_fill_controller;

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        block0_isLRU;
  logic        block1_isLRU;
  logic        mem_data_valid;
  logic        fsm_busy;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        write_data_array;
  logic [2:0]  word_offset;
  logic        fill_way;
  logic        write_tag_array;
  logic        lru_write_en;
  logic        lru_block;

  cache_fill_controller #(
    .ADDR_W(16),
    .WORDS_PER_BLOCK(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .miss_detected(miss_detected),
    .miss_address(miss_address),
    .block0_isLRU(block0_isLRU),
    .block1_isLRU(block1_isLRU),
    .mem_data_valid(mem_data_valid),
    .fsm_busy(fsm_busy),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .write_data_array(write_data_array),
    .word_offset(word_offset),
    .fill_way(fill_way),
    .write_tag_array(write_tag_array),
    .lru_write_en(lru_write_en),
    .lru_block(lru_block)
  );

  int total = 0;
  int bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int cyc = 0;
  int lat = 4;
  bit mode_gap = 0;
  bit extra_valid = 0;
  int iq[$];

  always @(posedge clk) begin
    bit v;
    #1;
    cyc++;
    if (!rst) begin
      iq.delete();
      mem_data_valid = 1'b0;
    end else begin
      v = 0;
      if (iq.size() > 0) begin
        if (mode_gap) v = (iq[0] < cyc) && ($urandom_range(0, 2) != 0);
        else          v = (iq[0] + lat <= cyc);
      end
      if (v) void'(iq.pop_front());
      mem_data_valid = v | extra_valid;
    end
  end

  // ---------------- model, monitor, compare ----------------
  bit          m_busy, m_done, m_way;
  int          m_issued, m_recv;
  logic [15:0] m_base;

  logic [15:0] addr_log[$];
  int          off_log[$];
  int          busy_cnt, tag_cnt, lru_cnt, wr_cnt;
  int          tag_cyc, last_wr_cyc, tag_way, tag_lb;
  int          ncyc = 0;

  task automatic clear_logs();
    addr_log.delete();
    off_log.delete();
    busy_cnt = 0;
    tag_cnt  = 0;
    lru_cnt  = 0;
    wr_cnt   = 0;
  endtask

  always @(negedge clk) begin
    bit          fa, e_en, e_wda;
    logic [15:0] e_addr;
    int          e_off;
    ncyc++;
    if (!rst) begin
      m_busy = 0; m_done = 0; m_way = 0;
      m_issued = 0; m_recv = 0; m_base = '0;
    end else begin
      fa     = m_busy && !m_done;
      e_en   = fa && (m_issued < 8);
      e_addr = e_en ? 16'(m_base + 16'(2 * m_issued)) : 16'h0;
      e_wda  = fa && mem_data_valid && (m_recv < 8);
      e_off  = e_wda ? m_recv : 0;
      total++;
      if (fsm_busy !== m_busy || mem_en !== e_en
          || mem_addr !== e_addr || write_data_array !== e_wda
          || int'(word_offset) != e_off || fill_way !== m_way
          || write_tag_array !== m_done || lru_write_en !== m_done
          || lru_block !== (m_done & ~m_way)) begin
        bad++;
        $display("FAIL cycle_model @%0d: got b%0b e%0b a%h w%0b o%0d f%0b t%0b l%0b lb%0b want b%0b e%0b a%h w%0b o%0d f%0b t%0b l%0b lb%0b",
          ncyc, fsm_busy, mem_en, mem_addr, write_data_array,
          word_offset, fill_way, write_tag_array, lru_write_en,
          lru_block, m_busy, e_en, e_addr, e_wda, e_off, m_way,
          m_done, m_done, m_done & ~m_way);
      end
      if (mem_en) begin
        addr_log.push_back(mem_addr);
        iq.push_back(cyc);
      end
      if (write_data_array) begin
        off_log.push_back(int'(word_offset));
        wr_cnt++;
        last_wr_cyc = ncyc;
      end
      if (write_tag_array) begin
        tag_cnt++;
        tag_cyc = ncyc;
        tag_way = int'(fill_way);
        tag_lb  = int'(lru_block);
      end
      if (lru_write_en) lru_cnt++;
      if (fsm_busy) busy_cnt++;
      // advance model
      if (!m_busy) begin
        if (miss_detected) begin
          m_busy = 1; m_issued = 0; m_recv = 0;
          m_base = miss_address & 16'hFFF0;
          m_way  = block1_isLRU && !block0_isLRU;
        end
      end else if (m_done) begin
        m_busy = 0;
        m_done = 0;
      end else begin
        if (m_issued < 8) m_issued++;
        if (mem_data_valid && m_recv < 8) begin
          m_recv++;
          if (m_recv == 8) m_done = 1;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_level(input bit lvl, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fsm_busy !== lvl && n < 300);
    if (fsm_busy !== lvl) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic run_fill(input logic [15:0] a, input bit b0,
                          input bit b1, input int hold);
    @(posedge clk); #1;
    clear_logs();
    miss_address  = a;
    block0_isLRU  = b0;
    block1_isLRU  = b1;
    miss_detected = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    miss_detected = 1'b0;
    miss_address  = 16'($urandom);
    block0_isLRU  = 1'($urandom);
    block1_isLRU  = 1'($urandom);
    wait_level(1'b0, "fill_end");
  endtask

  function automatic int outs();
    return int'({fsm_busy, mem_en, mem_addr, write_data_array,
                 word_offset, fill_way, write_tag_array,
                 lru_write_en, lru_block});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = '0;
    block0_isLRU = 1'b0;
    block1_isLRU = 1'b0;
    mem_data_valid = 1'b0;
    clear_logs();
    #2 rst = 1'b0;
    #1 chk("reset_outputs", outs(), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // latency-4 memory, addressing from 0x1237
    lat = 4; mode_gap = 0;
    run_fill(16'h1237, 1'b1, 1'b0, 1);
    chk("lat4_addr_count", addr_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("lat4_addr", (i < addr_log.size()) ? int'(addr_log[i]) : -1,
          32'h1230 + 2 * i);
      chk("lat4_offset", (i < off_log.size()) ? off_log[i] : -1, i);
    end
    chk("lat4_busy_cycles", busy_cnt, 13);
    chk("lat4_done_after_last", tag_cyc - last_wr_cyc, 1);
    chk("lat4_tag_pulses", tag_cnt, 1);
    chk("lat4_lru_pulses", lru_cnt, 1);
    chk("lat4_fill_way", tag_way, 0);
    chk("lat4_lru_block", tag_lb, 1);

    // victim choice with gapped returns
    mode_gap = 1;
    run_fill(16'($urandom), 1'b0, 1'b1, 1);
    chk("vict01_way", tag_way, 1);
    chk("vict01_lru_block", tag_lb, 0);
    chk("vict01_writes", off_log.size(), 8);
    chk("vict01_tag_pulses", tag_cnt, 1);
    run_fill(16'($urandom), 1'b1, 1'b1, 1);
    chk("vict11_way", tag_way, 0);
    chk("vict11_lru_block", tag_lb, 1);
    run_fill(16'($urandom), 1'b0, 1'b0, 1);
    chk("vict00_way", tag_way, 0);
    chk("gap_writes", wr_cnt, 8);
    chk("gap_tag_pulses", tag_cnt, 1);

    // extra valid while idle
    @(posedge clk); #1;
    clear_logs();
    extra_valid = 1;
    repeat (5) @(posedge clk);
    #1 extra_valid = 0;
    @(negedge clk);
    chk("idle_valid_writes", wr_cnt, 0);

    // wrap address, held miss retriggers
    mode_gap = 0; lat = 2;
    @(posedge clk); #1;
    clear_logs();
    miss_address = 16'hFFF4;
    block0_isLRU = 1'b1;
    block1_isLRU = 1'b0;
    miss_detected = 1'b1;
    wait_level(1'b1, "b2b_start");
    wait_level(1'b0, "b2b_first_end");
    chk("wrap_addr_count", addr_log.size(), 8);
    chk("wrap_first_addr", int'(addr_log[0]), 32'hFFF0);
    chk("wrap_last_addr", int'(addr_log[addr_log.size()-1]), 32'hFFFE);
    @(negedge clk);
    chk("b2b_restart", int'(fsm_busy), 1);
    @(posedge clk); #1 miss_detected = 1'b0;
    wait_level(1'b0, "b2b_second_end");
    chk("b2b_tag_pulses", tag_cnt, 2);
    chk("b2b_writes", wr_cnt, 16);

    // reset in the middle of a fill
    lat = 4;
    @(posedge clk); #1;
    clear_logs();
    miss_address = 16'($urandom);
    miss_detected = 1'b1;
    @(posedge clk); #1 miss_detected = 1'b0;
    begin
      int n = 0;
      while (wr_cnt < 3 && n < 100) begin @(negedge clk); n++; end
      chk("midrst_reach3", int'(wr_cnt >= 3), 1);
    end
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("midrst_outputs", outs(), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_no_tag", tag_cnt, 0);
    chk("midrst_no_lru", lru_cnt, 0);

    // randomized fills
    begin
      int fills = 0, tags = 0, wrs = 0;
      for (int i = 0; i < 25; i++) begin
        int h;
        mode_gap = 1'($urandom);
        lat = $urandom_range(1, 6);
        h = ($urandom_range(0, 3) == 0) ? 15 : $urandom_range(1, 3);
        run_fill(16'($urandom), 1'($urandom), 1'($urandom), h);
        tags += tag_cnt;
        wrs += wr_cnt;
        fills++;
      end
      chk("rand_writes_per_tag", wrs, 8 * tags);
      chk("rand_min_fills", int'(tags >= fills), 1);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
